uart_tx_arbiter: RTL and testbench

//  Shares one uart_core_tx among NUM_REQ byte requesters. Round-robin grant per packet, optional

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_core_tx among NUM_REQ byte requesters.
// Round-robin per packet, optional packet lock with idle timeout.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/data/last      per-requester byte request (data lane i at [8*i+:8])
//   req_done                 1-cycle completion pulse for the granted requester
//   grant_id, lock_act, busy arbiter status
//   core_en, core_data       registered request toward uart_core_tx
//   core_busy, core_ack      status back from uart_core_tx
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2,
  parameter bit LOCK_EN      = 1'b1,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [REQ_ID_WIDTH-1:0] grant_id,
  output logic                    lock_act,
  output logic                    busy,
  output logic                    core_en,
  output logic [7:0]              core_data,
  input  logic                    core_busy,
  input  logic                    core_ack
);

  localparam int TW = (LOCK_TIMEOUT > 255) ? 16 : 8;
  localparam logic [TW-1:0] TO   = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TMAX = '1;
  localparam int CW = REQ_ID_WIDTH + 1;
  localparam logic [REQ_ID_WIDTH-1:0] LAST_ID =
    REQ_ID_WIDTH'(NUM_REQ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [REQ_ID_WIDTH-1:0] grant_q, grant_d;
  logic [REQ_ID_WIDTH-1:0] rr_q, rr_d;
  logic [7:0]              data_q, data_d;
  logic                    last_q, last_d;
  logic                    lock_q, lock_d;
  logic                    en_q, en_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [TW-1:0]           timer_q, timer_d;

  logic [7:0]              lane [NUM_REQ];
  logic                    pick_vld;
  logic [REQ_ID_WIDTH-1:0] pick_id;
  logic [REQ_ID_WIDTH-1:0] sel_id;
  logic [REQ_ID_WIDTH-1:0] grant_nxt;
  logic [CW-1:0]           cand;
  logic                    issue;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane[i] = req_data[8*i +: 8];
    end
  end

  // First valid requester at or after rr_q, wrapping. Scanning from
  // the far end lets the nearest candidate overwrite the others.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (req_valid[cand[REQ_ID_WIDTH-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = cand[REQ_ID_WIDTH-1:0];
      end
    end
  end

  // While locked only the lock owner may be served.
  assign sel_id    = lock_q ? grant_q : pick_id;
  assign issue     = lock_q ? req_valid[grant_q] : pick_vld;
  assign grant_nxt = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    data_d  = data_q;
    last_d  = last_q;
    lock_d  = lock_q;
    en_d    = en_q;
    done_d  = '0;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue && !core_busy) begin
          grant_d = sel_id;
          data_d  = lane[sel_id];
          last_d  = req_last[sel_id];
          en_d    = 1'b1;
          state_d = S_ISSUE;
        end else if (lock_q && !issue) begin
          if (LOCK_TIMEOUT != 0 && timer_q == TO) begin
            lock_d  = 1'b0;
            rr_d    = grant_nxt;
            timer_d = '0;
          end else if (timer_q != TMAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (core_busy) begin
          en_d    = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_ack) begin
          done_d[grant_q] = 1'b1;
          state_d         = S_DONE;
        end
      end
      default: begin
        if (LOCK_EN && !last_q) begin
          lock_d  = 1'b1;
          timer_d = '0;
        end else begin
          lock_d = 1'b0;
          rr_d   = grant_nxt;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      lock_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      en_q    <= en_d;
      done_q  <= done_d;
      timer_q <= timer_d;
    end
  end

  assign req_done  = done_q;
  assign grant_id  = grant_q;
  assign lock_act  = lock_q;
  assign busy      = (state_q != S_IDLE);
  assign core_en   = en_q;
  assign core_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and
// randomized packet traffic against a transaction-level arbiter model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_done;
  logic [1:0]  grant_id;
  logic        lock_act;
  logic        busy;
  logic        core_en;
  logic [7:0]  core_data;
  logic        core_busy;
  logic        core_ack;

  logic        cm_busy;
  logic        core_stall;
  int          cm_cnt;

  int n_vec;
  int n_err;

  uart_tx_arbiter #(
    .NUM_REQ(4), .REQ_ID_WIDTH(2),
    .LOCK_EN(1'b1), .LOCK_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_done(req_done),
    .grant_id(grant_id), .lock_act(lock_act),
    .busy(busy), .core_en(core_en),
    .core_data(core_data), .core_busy(core_busy),
    .core_ack(core_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural uart core: starts on en when idle, acks after a random
  // delay, goes idle the cycle after ack.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      cm_busy  = 1'b0;
      core_ack = 1'b0;
      cm_cnt   = 0;
    end else if (core_ack) begin
      core_ack = 1'b0;
      cm_busy  = 1'b0;
    end else if (cm_busy) begin
      if (cm_cnt == 0) core_ack = 1'b1;
      else cm_cnt--;
    end else if (core_en) begin
      cm_busy = 1'b1;
      cm_cnt  = $urandom_range(3, 0);
    end
  end
  assign core_busy = cm_busy | core_stall;

  initial begin
    #900000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    core_stall = 1'b0;
    step();
    chk("rst_state", {15'd0, req_done, grant_id, lock_act,
        busy, core_en, core_data}, 32'd0);
    step();
    rst = 1'b0;
  endtask

  task automatic run_byte(input logic [3:0] v, input logic [31:0] d,
                          input logic [3:0] l, input logic [1:0] eg,
                          input logic [7:0] ed);
    int   cyc;
    logic pa;
    req_valid = v;
    req_data  = d;
    req_last  = l;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!core_en && cyc < 20);
    chk("en_latency", cyc, 1);
    chk("grant", grant_id, eg);
    chk("data", core_data, ed);
    cyc = 0;
    pa  = 1'b0;
    while (req_done == 4'd0 && cyc < 50) begin
      pa = core_ack;
      step();
      cyc++;
    end
    chk("done_vec", req_done, 4'd1 << eg);
    chk("ack_to_done", pa, 1);
    chk("data_hold", core_data, ed);
    req_valid = '0;
    step();
    chk("back_idle", {busy, req_done}, 0);
  endtask

  function automatic logic [1:0] rr_pick(input logic [3:0] v,
                                         input logic [1:0] p);
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      if (v[(int'(p) + k) % 4]) rr_pick = 2'((int'(p) + k) % 4);
    end
  endfunction

  int np [4];
  int plen [4][3];
  int gap0 [4];
  int gapa [4][3];
  int f_pk [4];
  int f_bi [4];
  int f_gap [4];
  logic [1:0] glog [$];
  logic       llog [$];

  task automatic clr_cfg();
    for (int i = 0; i < 4; i++) begin
      np[i]   = 0;
      gap0[i] = 0;
      for (int p = 0; p < 3; p++) begin
        plen[i][p] = 1;
        gapa[i][p] = 0;
      end
    end
  endtask

  task automatic lanes_drive();
    for (int i = 0; i < 4; i++) begin
      if (!req_valid[i] && f_pk[i] < np[i]) begin
        if (f_gap[i] > 0) f_gap[i]--;
        else begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i]        = (f_bi[i] == plen[i][f_pk[i]] - 1);
        end
      end
    end
  endtask

  // Packet traffic from the np/plen/gap tables, checked against the
  // arbitration rules: locked -> owner, else round-robin from rr.
  task automatic run_feed(input int max_cyc);
    int cyc, tot, ndone;
    bit m_lock, en_p, out_v;
    logic [1:0] m_rr, m_own, eg, out_g;
    logic [7:0] out_d;
    logic out_l;
    logic [3:0] pv, pl;
    logic [31:0] pd;
    glog.delete();
    llog.delete();
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      f_pk[i]  = 0;
      f_bi[i]  = 0;
      f_gap[i] = gap0[i];
      for (int p = 0; p < np[i]; p++) tot += plen[i][p];
    end
    m_rr = 0; m_lock = 0; m_own = 0;
    en_p = 0; out_v = 0; out_g = 0; out_d = 0; out_l = 0;
    ndone = 0; cyc = 0;
    req_valid = '0;
    req_last  = '0;
    lanes_drive();
    pv = req_valid; pd = req_data; pl = req_last;
    while (ndone < tot && cyc < max_cyc) begin
      step();
      cyc++;
      chk("lock_state", lock_act, m_lock);
      if (core_en && !en_p) begin
        eg = m_lock ? m_own : rr_pick(pv, m_rr);
        chk("issue_req", m_lock ? pv[m_own] : |pv, 1);
        chk("f_grant", grant_id, eg);
        chk("f_data", core_data, pd[8*eg +: 8]);
        out_v = 1; out_g = eg;
        out_d = pd[8*eg +: 8]; out_l = pl[eg];
        glog.push_back(grant_id);
        llog.push_back(lock_act);
      end
      if (req_done != 4'd0) begin
        chk("f_done", req_done, out_v ? (4'd1 << out_g) : 4'd0);
        chk("f_hold", core_data, out_d);
        ndone++;
        out_v = 0;
        if (!out_l) begin
          m_lock = 1; m_own = out_g;
        end else begin
          m_lock = 0;
          m_rr   = 2'((int'(out_g) + 1) % 4);
        end
        f_bi[out_g]++;
        if (f_bi[out_g] == plen[out_g][f_pk[out_g]]) begin
          f_bi[out_g]  = 0;
          f_gap[out_g] = gapa[out_g][f_pk[out_g]];
          f_pk[out_g]++;
        end
        req_valid[out_g] = 1'b0;
      end
      en_p = core_en;
      lanes_drive();
      pv = req_valid; pd = req_data; pl = req_last;
    end
    if (ndone < tot) chk("feed_timeout", ndone, tot);
    req_valid = '0;
    repeat (3) step();
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic [1:0]  g;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int k;
    logic seen;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    core_stall = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;

    tbl[0] = '{4'b0100, 32'h00A5_0000, 4'b1111, 2'd2, 8'hA5};
    tbl[1] = '{4'b0011, 32'h4433_2211, 4'b1111, 2'd0, 8'h11};
    tbl[2] = '{4'b1001, 32'h8877_6655, 4'b1111, 2'd3, 8'h88};
    tbl[3] = '{4'b1111, 32'hDDCC_BBAA, 4'b1111, 2'd0, 8'hAA};
    tbl[4] = '{4'b1111, 32'h0F0E_0D0C, 4'b1111, 2'd1, 8'h0D};
    tbl[5] = '{4'b0011, 32'hF0E1_D2C3, 4'b1111, 2'd0, 8'hC3};
    tbl[6] = '{4'b1000, 32'h5A00_0000, 4'b1111, 2'd3, 8'h5A};
    tbl[7] = '{4'b0010, 32'h0000_FF00, 4'b1111, 2'd1, 8'hFF};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_byte(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].g, tbl[i].ed);
    end

    // fairness: four requesters, two single-byte packets each
    do_reset();
    clr_cfg();
    for (int i = 0; i < 4; i++) np[i] = 2;
    run_feed(2000);
    chk("fair_cnt", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) begin
      chk("fair_order", glog[i], i % 4);
    end

    // lock: req1 sends a 3-byte packet while req0/req2 wait
    do_reset();
    clr_cfg();
    np[0] = 1; np[1] = 1; np[2] = 1;
    plen[1][0] = 3;
    gap0[0] = 2;
    run_feed(2000);
    chk("lock_cnt", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("lock_g0", glog[0], 1); chk("lock_g1", glog[1], 1);
      chk("lock_g2", glog[2], 1); chk("lock_g3", glog[3], 2);
      chk("lock_g4", glog[4], 0);
      chk("lock_l0", llog[0], 0); chk("lock_l1", llog[1], 1);
      chk("lock_l2", llog[2], 1); chk("lock_l3", llog[3], 0);
    end

    // timeout: req1 locks then goes away; 16 idle cycles then release
    do_reset();
    req_data  = 32'h006C_5B00;
    req_last  = 4'b0100;
    req_valid = 4'b0110;
    k = 0;
    do begin step(); k++; end while (!core_en && k < 20);
    chk("to_grant1", grant_id, 1);
    k = 0;
    do begin step(); k++; end while (req_done == 4'd0 && k < 50);
    chk("to_done1", req_done, 4'b0010);
    req_valid[1] = 1'b0;
    step();
    chk("to_lock_set", lock_act, 1);
    k = 1;
    while (lock_act && k < 40) begin step(); k++; end
    chk("to_release", k, 18);
    k = 0;
    do begin step(); k++; end while (!core_en && k < 10);
    chk("to_grant2", grant_id, 2);
    chk("to_data2", core_data, 8'h6C);
    k = 0;
    do begin step(); k++; end while (req_done == 4'd0 && k < 50);
    chk("to_done2", req_done, 4'b0100);
    req_valid = '0;
    repeat (3) step();

    // reset while the core is sending
    do_reset();
    req_data  = 32'h0000_0077;
    req_last  = 4'b0001;
    req_valid = 4'b0001;
    k = 0;
    do begin step(); k++; end
    while (!(busy && cm_busy && !core_en) && k < 20);
    chk("mid_wait", {busy, core_en}, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst", {core_en, req_done, busy}, 0);
    step();
    rst = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    repeat (6) begin step(); seen |= (req_done != 4'd0); end
    chk("mid_no_done", seen, 0);
    run_byte(4'b0010, 32'h0000_9900, 4'b1111, 2'd1, 8'h99);

    // back-pressure: core busy from an earlier transfer
    do_reset();
    core_stall = 1'b1;
    req_data  = 32'hE700_0000;
    req_last  = 4'b1000;
    req_valid = 4'b1000;
    seen = 1'b0;
    repeat (6) begin step(); seen |= core_en | busy; end
    chk("bp_hold", seen, 0);
    core_stall = 1'b0;
    run_byte(4'b1000, 32'hE700_0000, 4'b1000, 2'd3, 8'hE7);

    // randomized packet traffic
    for (int r = 0; r < 6; r++) begin
      do_reset();
      clr_cfg();
      for (int i = 0; i < 4; i++) begin
        np[i]   = $urandom_range(3, 1);
        gap0[i] = $urandom_range(8, 0);
        for (int p = 0; p < 3; p++) begin
          plen[i][p] = $urandom_range(3, 1);
          gapa[i][p] = $urandom_range(6, 0);
        end
      end
      run_feed(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
